mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port unified memory between two requesters: port m0 is the multicycle CPU (fetch and load/store, including byte access), and port m1 is the DMA/program loader.
- Sits between the CPU datapath/controller and the memory model.
- Sequences each access over a fixed memory latency and returns a one-cycle ack with registered read data.
- Rejects misaligned word accesses without touching memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, number of cycles memory needs per access; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU request; held high with stable fields until m0_ack.
- m0_we  in  1  CPU write (1) / read (0).
- m0_byte  in  1  CPU byte access (MemByte).
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_rdata  out  DATA_W  CPU read data, valid while m0_ack is high.
- m0_ack  out  1  one-cycle completion pulse to CPU.
- m0_err  out  1  misalign error, valid with m0_ack.
- m1_req, m1_we, m1_byte, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as the m0 ports, for DMA/loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_byte  out  1  byte lane access.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid on the last access cycle.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  current or last grantee (0 = m0, 1 = m1).

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, counter = 0, and all outputs = 0 including rdata registers and owner.
  - An access in flight is aborted: no ack is issued and mem_en drops immediately.
- States: IDLE, ACCESS, ERR, DONE. Every output is registered.
- IDLE:
  - With no req: stay in IDLE.
  - With any req: pick a winner (see priority) and latch its fields into the mem_* outputs; owner = winner.
  - If the winner's request is a word access (byte = 0) with addr[1:0] != 2'b00 → ERR; mem_en stays 0.
  - Otherwise → ACCESS, with mem_en = 1, mem_we = winner we, and counter = MEM_LAT-1.
- ACCESS:
  - mem_* outputs are held stable.
  - While counter != 0: decrement the counter and stay.
  - When counter == 0: capture mem_rdata into the winner's rdata register; drop mem_en and mem_we; → DONE.
  - Writes commit at this final edge. For writes the rdata register is left unchanged.
- ERR: → DONE, and the winner's err is set.
- DONE:
  - Winner's ack = 1 for exactly this cycle. The other port's ack and err stay 0.
  - → IDLE, clearing ack and err on exit.
- Latency, req sampled to ack high:
  - Valid access: MEM_LAT+1 cycles.
  - Misaligned access: 2 cycles.
- Handshake:
  - The requester must deassert req in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
  - Req changes during ACCESS are ignored.
- Priority (default): fixed; m0 wins when both requesters are active.
- Byte accesses:
  - Passed through unchanged; lane select and extension belong to the datapath.
  - Byte accesses are never misaligned.
- Back-to-back accesses: a minimum of one IDLE cycle between grants.
- MEM_LAT = 1: ACCESS lasts one cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-served pointer is updated on every DONE.
  - On a simultaneous request, the port not served last wins.
  - The pointer resets to 1, so m0 wins the first tie.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed m0 priority, and no pointer register exists.

Decomposition:
- define.vh holds:
  - state encodings ARB_IDLE, ARB_ACCESS, ARB_ERR, ARB_DONE;
  - owner codes ARB_M0, ARB_M1;
  - the misalign mask constant.
- One sub-module, arb_pick: combinational winner select from m0_req, m1_req and the last pointer, with the round-robin logic under the macro.
- Counter, FSM and datapath latches stay in mem_arbiter.

Test Plan:
- MEM_LAT = 2; m0 reads 0x0000_0010 with mem_rdata = 0xDEAD_BEEF → m0_ack high 3 cycles after req, m0_rdata = 0xDEADBEEF, m1_ack = 0, mem_en high for exactly 2 cycles.
- m0 and m1 both request in the same cycle:
  - default → m0 served first, m1's ack follows 4 cycles later;
  - MEM_ARB_RR_EN → m0 first, then repeat the tie → m1 wins.
- m1 word write to 0x0000_0102 → no mem_en, m1_ack and m1_err high 2 cycles after req.
- m1 byte write 0x0000_0103 → accepted normally, mem_byte = 1, err = 0.
- rst pulled low in the second ACCESS cycle of m0 write 0x20 = 0x1234_5678 → mem_en and mem_we drop asynchronously, no ack, busy = 0. After release, an idle arbiter grants the next req.
- MEM_LAT = 1; m0 holds req high across ack → two back-to-back accesses, acks 3 cycles apart, one IDLE gap.
- MEM_LAT = 7; m0 read → ack exactly 8 cycles after req, counter wraps from 6 down to 0 without underflow.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encodings, owner codes and the word-alignment check used by mem_arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_ERR, ARB_DONE} arb_state_e;
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;
  localparam logic [1:0] ARB_MISALIGN_MASK = 2'b11;
  function automatic logic misaligned(input logic byte_acc, input logic [1:0] lsb);
    return !byte_acc && ((lsb & ARB_MISALIGN_MASK) != 2'b00);
  endfunction
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// mem_arbiter_arb_pick: combinational winner select; round-robin on ties when MEM_ARB_RR_EN is defined.
module mem_arbiter_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic win_o
);
`ifdef MEM_ARB_RR_EN
  assign win_o = (req0_i && req1_i) ? ~last_i : (req0_i ? ARB_M0 : ARB_M1);
`else
  assign win_o = (req0_i || !req1_i) ? ARB_M0 : ARB_M1;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port memory between the CPU (m0) and the DMA/loader (m1).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  arb_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic owner_q, owner_d, en_q, en_d, we_q, we_d, byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d, busy_q, busy_d;
  logic win, any_req, w_we, w_byte, mis, grant, fin;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
`endif
  mem_arbiter_arb_pick u_arb_pick (
    .req0_i(m0_req),
    .req1_i(m1_req),
`ifdef MEM_ARB_RR_EN
    .last_i(last_q),
`endif
    .win_o (win)
  );
  assign any_req = m0_req || m1_req;
  assign w_we    = win ? m1_we : m0_we;
  assign w_byte  = win ? m1_byte : m0_byte;
  assign w_addr  = win ? m1_addr : m0_addr;
  assign w_wdata = win ? m1_wdata : m0_wdata;
  assign mis     = misaligned(w_byte, w_addr[1:0]);
  // State, counter and every output register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      owner_q <= ARB_M0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= ARB_M1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      busy_q  <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end
  // Next state: misaligned word accesses skip memory via ERR; valid ones count down the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: if (any_req) begin
        state_d = mis ? ARB_ERR : ARB_ACCESS;
        cnt_d   = mis ? cnt_q : LAT_M1;
      end
      ARB_ACCESS: if (cnt_q != '0) cnt_d = cnt_q - 3'd1;
                  else state_d = ARB_DONE;
      ARB_ERR: state_d = ARB_DONE;
      default: state_d = ARB_IDLE;
    endcase
  end
  // Output next values: latch the winner on grant, hold through ACCESS, pulse ack/err in DONE.
  always_comb begin
    grant   = (state_q == ARB_IDLE) && any_req;
    fin     = (state_q == ARB_ACCESS) && (cnt_q == '0);
    owner_d = grant ? win : owner_q;
    en_d    = grant ? !mis : (fin ? 1'b0 : en_q);
    we_d    = grant ? (!mis && w_we) : (fin ? 1'b0 : we_q);
    byte_d  = grant ? w_byte : byte_q;
    addr_d  = grant ? w_addr : addr_q;
    wdata_d = grant ? w_wdata : wdata_q;
    rd0_d   = (fin && !we_q && owner_q == ARB_M0) ? mem_rdata : rd0_q;
    rd1_d   = (fin && !we_q && owner_q == ARB_M1) ? mem_rdata : rd1_q;
    ack0_d  = (fin || state_q == ARB_ERR) && owner_q == ARB_M0;
    ack1_d  = (fin || state_q == ARB_ERR) && owner_q == ARB_M1;
    err0_d  = (state_q == ARB_ERR) && owner_q == ARB_M0;
    err1_d  = (state_q == ARB_ERR) && owner_q == ARB_M1;
    busy_d  = state_d != ARB_IDLE;
`ifdef MEM_ARB_RR_EN
    last_d  = (state_q == ARB_DONE) ? owner_q : last_q;
`endif
  end
  assign m0_rdata  = rd0_q;
  assign m0_ack    = ack0_q;
  assign m0_err    = err0_q;
  assign m1_rdata  = rd1_q;
  assign m1_ack    = ack1_q;
  assign m1_err    = err1_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_byte  = byte_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (MEM_LAT 2, 1, 7) checked every cycle against a transaction-timing model.
module tb_mem_arbiter;
  logic clk, rst;
  logic m0_req[3], m0_we[3], m0_byte[3], m1_req[3], m1_we[3], m1_byte[3];
  logic [31:0] m0_addr[3], m0_wdata[3], m1_addr[3], m1_wdata[3], mem_rdata[3];
  logic [31:0] m0_rdata[3], m1_rdata[3], mem_addr[3], mem_wdata[3];
  logic m0_ack[3], m0_err[3], m1_ack[3], m1_err[3], mem_en[3], mem_we[3], mem_byte[3], busy[3], owner[3];
  int total = 0, bad = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 7))) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_byte(m0_byte[g]), .m0_addr(m0_addr[g]),
      .m0_wdata(m0_wdata[g]), .m0_rdata(m0_rdata[g]), .m0_ack(m0_ack[g]), .m0_err(m0_err[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_byte(m1_byte[g]), .m1_addr(m1_addr[g]),
      .m1_wdata(m1_wdata[g]), .m1_rdata(m1_rdata[g]), .m1_ack(m1_ack[g]), .m1_err(m1_err[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_byte(mem_byte[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int lat(input int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 7);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // Model: one transaction per arbiter, described by its grant cycle t0 and offsets from it.
  int cyc;
  int m_t0[3];
  logic m_act[3], m_mis[3], m_we[3], m_byte[3], m_own[3], m_last[3];
  logic [31:0] m_addr[3], m_wd[3], m_rd0[3], m_rd1[3];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_act[k] <= 1'b0; m_mis[k] <= 1'b0; m_we[k] <= 1'b0; m_byte[k] <= 1'b0;
        m_own[k] <= 1'b0; m_last[k] <= 1'b1; m_addr[k] <= '0; m_wd[k] <= '0;
        m_rd0[k] <= '0; m_rd1[k] <= '0; m_t0[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_act[k]) begin
          if (!m_mis[k] && !m_we[k] && cyc - m_t0[k] == lat(k) - 1) begin
            if (m_own[k]) m_rd1[k] <= mem_rdata[k];
            else m_rd0[k] <= mem_rdata[k];
          end
          if (cyc - m_t0[k] == (m_mis[k] ? 1 : lat(k))) begin
            m_act[k] <= 1'b0;
            m_last[k] <= m_own[k];
          end
        end else if (m0_req[k] || m1_req[k]) begin
          logic w;
`ifdef MEM_ARB_RR_EN
          w = (m0_req[k] && m1_req[k]) ? !m_last[k] : !m0_req[k];
`else
          w = !m0_req[k];
`endif
          m_own[k]  <= w;
          m_act[k]  <= 1'b1;
          m_t0[k]   <= cyc + 1;
          m_we[k]   <= w ? m1_we[k] : m0_we[k];
          m_byte[k] <= w ? m1_byte[k] : m0_byte[k];
          m_addr[k] <= w ? m1_addr[k] : m0_addr[k];
          m_wd[k]   <= w ? m1_wdata[k] : m0_wdata[k];
          m_mis[k]  <= !(w ? m1_byte[k] : m0_byte[k]) && ((w ? m1_addr[k][1:0] : m0_addr[k][1:0]) != 2'b00);
        end
      end
      cyc <= cyc + 1;
    end
  end
  int c_d, c_e;
  logic c_en, c_ak;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      c_d  = cyc - m_t0[k];
      c_e  = m_mis[k] ? 1 : lat(k);
      c_en = m_act[k] && !m_mis[k] && c_d < lat(k);
      c_ak = m_act[k] && c_d == c_e;
      chk($sformatf("i%0d mem_en", k), 32'(mem_en[k]), 32'(c_en));
      chk($sformatf("i%0d mem_we", k), 32'(mem_we[k]), 32'(c_en && m_we[k]));
      chk($sformatf("i%0d mem_byte", k), 32'(mem_byte[k]), 32'(m_byte[k]));
      chk($sformatf("i%0d mem_addr", k), mem_addr[k], m_addr[k]);
      chk($sformatf("i%0d mem_wdata", k), mem_wdata[k], m_wd[k]);
      chk($sformatf("i%0d m0_ack", k), 32'(m0_ack[k]), 32'(c_ak && !m_own[k]));
      chk($sformatf("i%0d m1_ack", k), 32'(m1_ack[k]), 32'(c_ak && m_own[k]));
      chk($sformatf("i%0d m0_err", k), 32'(m0_err[k]), 32'(c_ak && !m_own[k] && m_mis[k]));
      chk($sformatf("i%0d m1_err", k), 32'(m1_err[k]), 32'(c_ak && m_own[k] && m_mis[k]));
      chk($sformatf("i%0d m0_rdata", k), m0_rdata[k], m_rd0[k]);
      chk($sformatf("i%0d m1_rdata", k), m1_rdata[k], m_rd1[k]);
      chk($sformatf("i%0d busy", k), 32'(busy[k]), 32'(m_act[k]));
      chk($sformatf("i%0d owner", k), 32'(owner[k]), 32'(m_own[k]));
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_port(input int k, input logic p, input logic we, input logic byt,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      m1_we[k] = we; m1_byte[k] = byt; m1_addr[k] = a; m1_wdata[k] = wd;
    end else begin
      m0_we[k] = we; m0_byte[k] = byt; m0_addr[k] = a; m0_wdata[k] = wd;
    end
  endtask
  // Raise requests (cycle 0), hold each until it has collected its acks; ack cycles are offsets from cycle 0.
  task automatic serve(input int k, input int n0, input int n1,
                       output int a0, output int b0, output int a1, output int b1,
                       output int en_n, output logic e0, output logic e1);
    int c0, c1, n;
    c0 = 0; c1 = 0; n = 0; a0 = -1; b0 = -1; a1 = -1; b1 = -1; en_n = 0; e0 = 1'b0; e1 = 1'b0;
    m0_req[k] = n0 > 0;
    m1_req[k] = n1 > 0;
    while ((c0 < n0 || c1 < n1) && n < 40) begin
      tick(1);
      n++;
      if (mem_en[k]) en_n++;
      if (m0_ack[k]) begin
        if (c0 == 0) a0 = n; else b0 = n;
        c0++;
        e0 = e0 | m0_err[k];
        if (c0 >= n0) m0_req[k] = 1'b0;
      end
      if (m1_ack[k]) begin
        if (c1 == 0) a1 = n; else b1 = n;
        c1++;
        e1 = e1 | m1_err[k];
        if (c1 >= n1) m1_req[k] = 1'b0;
      end
    end
    m0_req[k] = 1'b0;
    m1_req[k] = 1'b0;
  endtask
  int a0, b0, a1, b1, en_n;
  logic e0, e1;
  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m0_req[k] = 0; m0_we[k] = 0; m0_byte[k] = 0; m0_addr[k] = 0; m0_wdata[k] = 0;
      m1_req[k] = 0; m1_we[k] = 0; m1_byte[k] = 0; m1_addr[k] = 0; m1_wdata[k] = 0;
      mem_rdata[k] = 0;
    end
    tick(2);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset owner", 32'(owner[0]), 32'd0);
    chk("reset mem_en", 32'(mem_en[0]), 32'd0);
    chk("reset m0_rdata", m0_rdata[0], 32'd0);
    rst = 1'b1;
    tick(2);
    mem_rdata[0] = 32'hDEAD_BEEF;
    set_port(0, 0, 0, 0, 32'h0000_0010, 32'h0);
    serve(0, 1, 0, a0, b0, a1, b1, en_n, e0, e1);
    chk("read ack cycle", a0, 3);
    chk("read en cycles", en_n, 2);
    chk("read err", 32'(e0), 0);
    chk("read m1 ack", a1, -1);
    chk("read rdata", m0_rdata[0], 32'hDEAD_BEEF);
    tick(2);
    set_port(0, 1, 1, 0, 32'h0000_0102, 32'h5555_5555);
    serve(0, 0, 1, a0, b0, a1, b1, en_n, e0, e1);
    chk("misalign ack cycle", a1, 2);
    chk("misalign err", 32'(e1), 1);
    chk("misalign en cycles", en_n, 0);
    chk("misalign m0 ack", a0, -1);
    tick(2);
    set_port(0, 1, 1, 1, 32'h0000_0103, 32'h0000_00AB);
    serve(0, 0, 1, a0, b0, a1, b1, en_n, e0, e1);
    chk("byte ack cycle", a1, 3);
    chk("byte err", 32'(e1), 0);
    chk("byte mem_byte", 32'(mem_byte[0]), 1);
    chk("byte mem_addr", mem_addr[0], 32'h0000_0103);
    chk("byte write keeps rdata", m1_rdata[0], 32'h0);
    tick(2);
    mem_rdata[0] = 32'h1111_2222;
    set_port(0, 0, 0, 0, 32'h0000_0040, 32'h0);
    set_port(0, 1, 0, 0, 32'h0000_0080, 32'h0);
    serve(0, 1, 1, a0, b0, a1, b1, en_n, e0, e1);
    chk("tie m0 ack", a0, 3);
    chk("tie m1 ack", a1, 7);
    chk("tie m1 rdata", m1_rdata[0], 32'h1111_2222);
    tick(2);
    serve(0, 2, 1, a0, b0, a1, b1, en_n, e0, e1);
    chk("repeat tie m0 first", a0, 3);
`ifdef MEM_ARB_RR_EN
    chk("repeat tie m1", a1, 7);
    chk("repeat tie m0 second", b0, 11);
`else
    chk("repeat tie m0 second", b0, 7);
    chk("repeat tie m1", a1, 11);
`endif
    tick(2);
    set_port(0, 0, 1, 0, 32'h0000_0020, 32'h1234_5678);
    m0_req[0] = 1'b1;
    tick(2);
    chk("pre-reset mem_en", 32'(mem_en[0]), 1);
    chk("pre-reset mem_we", 32'(mem_we[0]), 1);
    rst = 1'b0;
    #1;
    chk("async reset mem_en", 32'(mem_en[0]), 0);
    chk("async reset mem_we", 32'(mem_we[0]), 0);
    chk("async reset busy", 32'(busy[0]), 0);
    m0_req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("no ack in reset", 32'(m0_ack[0]), 0);
    end
    rst = 1'b1;
    tick(1);
    mem_rdata[0] = 32'hCAFE_F00D;
    set_port(0, 0, 0, 0, 32'h0000_0024, 32'h0);
    serve(0, 1, 0, a0, b0, a1, b1, en_n, e0, e1);
    chk("post-reset ack cycle", a0, 3);
    chk("post-reset rdata", m0_rdata[0], 32'hCAFE_F00D);
    tick(2);
    mem_rdata[1] = 32'h0102_0304;
    set_port(1, 0, 0, 0, 32'h0000_0200, 32'h0);
    serve(1, 2, 0, a0, b0, a1, b1, en_n, e0, e1);
    chk("lat1 first ack", a0, 2);
    chk("lat1 second ack", b0, 5);
    chk("lat1 rdata", m0_rdata[1], 32'h0102_0304);
    tick(2);
    mem_rdata[2] = 32'hA5A5_A5A5;
    set_port(2, 0, 0, 0, 32'h0000_0300, 32'h0);
    serve(2, 1, 0, a0, b0, a1, b1, en_n, e0, e1);
    chk("lat7 ack cycle", a0, 8);
    chk("lat7 en cycles", en_n, 7);
    chk("lat7 rdata", m0_rdata[2], 32'hA5A5_A5A5);
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
